// File: rtl/desen_pkg.sv
// Shared types and default constants for the desense word generator.
package desen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    MODE_SUM  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  localparam logic [11:0] DEF_POLY    = 12'hE08;
  localparam logic [3:0]  DEF_MAP_KEY = 4'h5;

endpackage

// File: rtl/desen_gen_if.sv
// Control inputs and valid/ready output stream of desen_gen; master = generator side.
interface desen_gen_if #(
  parameter int DW = 4,
  parameter int SW = 12
);

  logic          start;
  logic          stop;
  logic          mode;
  logic [SW-1:0] seed;
  logic [SW-1:0] prev;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          running;
  logic [DW-1:0] count;
`ifdef DESEN_GEN_PARITY_EN
  logic          par_out;
`endif

  modport master (
`ifdef DESEN_GEN_PARITY_EN
    output par_out,
`endif
    input  start, stop, mode, seed, prev, out_ready,
    output data_out, out_valid, running, count
  );

  modport slave (
`ifdef DESEN_GEN_PARITY_EN
    input  par_out,
`endif
    output start, stop, mode, seed, prev, out_ready,
    input  data_out, out_valid, running, count
  );

endinterface

// File: rtl/desen_map.sv
// Output mapper: bit-reverse the raw word then XOR with MAP_KEY. Purely combinational.
module desen_map #(
  parameter int            DW      = 4,
  parameter logic [DW-1:0] MAP_KEY = DW'(4'h5)
) (
  input  logic [DW-1:0] x_i,
  output logic [DW-1:0] y_o
);

  always_comb begin
    y_o = MAP_KEY;
    for (int i = 0; i < DW; i++) begin
      y_o[i] = x_i[DW-1-i] ^ MAP_KEY[i];
    end
  end

endmodule

// File: rtl/desen_gen.sv
// Desense word generator (sum or Galois-LFSR) behind valid/ready; DESEN_GEN_PARITY_EN adds par_out.
// First word one cycle after an accepted start; HOLD freezes data_out while out_ready is low.
module desen_gen
  import desen_pkg::*;
#(
  parameter int            DW      = 4,
  parameter int            SW      = 12,
  parameter logic [SW-1:0] POLY    = SW'(DEF_POLY),
  parameter logic [DW-1:0] MAP_KEY = DW'(DEF_MAP_KEY)
) (
  input  logic        clk,
  input  logic        rst,
  desen_gen_if.master bus
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d, mode_sel;
  logic [DW-1:0] count_q, count_d, count_inc, cnt_sel;
  logic [SW-1:0] lfsr_q, lfsr_d, lfsr_step, lfsr_sel, seed_load, sum_full;
  logic [DW-1:0] data_q, data_d, raw_word, map_word;
  logic          accept, load_data, gen_start, unused_sum;

  assign accept    = (state_q != ST_IDLE) && bus.out_ready;
  assign count_inc = count_q + DW'(1);
  assign seed_load = (bus.seed == '0) ? SW'(1) : bus.seed;

  // The all-zero LFSR state is a lock-up; it is never allowed to persist.
  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    if (lfsr_step == '0) begin
      lfsr_step = SW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    lfsr_d    = lfsr_q;
    load_data = 1'b0;
    gen_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(bus.mode);
          count_d   = '0;
          lfsr_d    = seed_load;
          load_data = 1'b1;
          gen_start = 1'b1;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (accept) begin
          count_d = count_inc;
          if (mode_q == MODE_LFSR) begin
            lfsr_d = lfsr_step;
          end
        end
        // A word taken in the stop cycle still counts, but data_out keeps the last offered word.
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          state_d   = ST_RUN;
          load_data = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_sel   = gen_start ? mode_e'(bus.mode) : mode_q;
    cnt_sel    = gen_start ? '0 : count_inc;
    lfsr_sel   = gen_start ? seed_load : lfsr_step;
    sum_full   = bus.seed + bus.prev + SW'(cnt_sel);
    unused_sum = ^sum_full;
    raw_word   = (mode_sel == MODE_LFSR) ? lfsr_sel[DW-1:0] : sum_full[DW-1:0];
    data_d     = load_data ? map_word : data_q;
  end

  desen_map #(
    .DW      (DW),
    .MAP_KEY (MAP_KEY)
  ) u_map (
    .x_i (raw_word),
    .y_o (map_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SUM;
      count_q <= '0;
      lfsr_q  <= SW'(1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
    end
  end

`ifdef DESEN_GEN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load_data) begin
      par_q <= ^map_word;
    end
  end

  assign bus.par_out = par_q;
`endif

  assign bus.data_out  = data_q;
  assign bus.count     = count_q;
  assign bus.out_valid = (state_q != ST_IDLE);
  assign bus.running   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_desen_gen.sv
// Bench for desen_gen: directed literal checks plus randomized traffic against an arithmetic model.
module tb_desen_gen;

  localparam int DW   = 4;
  localparam int SW   = 12;
  localparam int M    = 1 << DW;
  localparam int POLY = 12'hE08;
  localparam int KEY  = 5;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 0;

  desen_gen_if #(.DW(DW), .SW(SW)) bus ();

  desen_gen #(.DW(DW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int f_map(input int x);
    int r = 0;
    for (int i = 0; i < DW; i++) begin
      if (((x >> i) & 1) != 0) r |= 1 << (DW - 1 - i);
    end
    return r ^ KEY;
  endfunction

  function automatic int f_step(input int l);
    int n = (l >> 1) ^ (((l & 1) != 0) ? POLY : 0);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int f_par(input int x);
    int p = 0;
    for (int i = 0; i < DW; i++) p ^= (x >> i) & 1;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: active flag, counter, LFSR value and the word on offer.
  bit m_act = 0;
  bit m_lmode = 0;
  int m_cnt = 0;
  int m_lfsr = 1;
  int m_data = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_lmode = 0; m_cnt = 0; m_lfsr = 1; m_data = 0;
    end else if (!m_act) begin
      if (bus.start && !bus.stop) begin
        m_act   = 1;
        m_lmode = bus.mode;
        m_cnt   = 0;
        m_lfsr  = (bus.seed == 0) ? 1 : int'(bus.seed);
        m_data  = m_lmode ? f_map(m_lfsr % M) : f_map((int'(bus.seed) + int'(bus.prev)) % M);
      end
    end else begin
      if (bus.out_ready) begin
        m_cnt = (m_cnt + 1) % M;
        if (m_lmode) m_lfsr = f_step(m_lfsr);
      end
      if (bus.stop) m_act = 0;
      else if (bus.out_ready)
        m_data = m_lmode ? f_map(m_lfsr % M)
                         : f_map((int'(bus.seed) + int'(bus.prev) + m_cnt) % M);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_act));
      check("running", 32'(bus.running), 32'(m_act));
      check("count", 32'(bus.count), 32'(m_cnt));
      if (m_act) check("data_out", 32'(bus.data_out), 32'(m_data));
`ifdef DESEN_GEN_PARITY_EN
      if (m_act) check("par_out", 32'(bus.par_out), 32'(f_par(m_data)));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int dat, input int cnt, input bit vld);
    check({name, "_valid"}, 32'(bus.out_valid), 32'(vld));
    check({name, "_count"}, 32'(bus.count), 32'(cnt));
    if (vld) check({name, "_data"}, 32'(bus.data_out), 32'(dat));
  endtask

  initial begin
    int per;
    int l;
    rst = 1'b1;
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.seed = '0; bus.prev = '0; bus.out_ready = 0;

    l = 1; per = 0;
    do begin l = f_step(l); per++; end while (l != 1 && per < 5000);
    check("lfsr_period_model", 32'(per), 32'd4095);

    repeat (3) step();
    rst = 1'b0;
    chk_en = 1;
    step();
    lit("reset", 0, 0, 0);
    check("reset_data", 32'(bus.data_out), 32'd0);
    check("reset_running", 32'(bus.running), 32'd0);

    // Sum mode seed=3 prev=2: map(5)=F, map(6)=3, map(7)=B, map(8)=4, map(9)=C.
    bus.start = 1; bus.mode = 0; bus.seed = 12'd3; bus.prev = 12'd2;
    step(); bus.start = 0;
    lit("sum0", 'hF, 0, 1);
    bus.out_ready = 1;
    step(); lit("sum1", 'h3, 1, 1);
    step(); lit("sum2", 'hB, 2, 1);
    step(); lit("sum3", 'h4, 3, 1);
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step(); lit("hold", 'h4, 3, 1);
    end
    bus.out_ready = 1;
    step(); lit("unhold", 'hC, 4, 1);

    bus.stop = 1;
    step(); bus.stop = 0;
    lit("stop_acc", 0, 5, 0);
    check("stop_running", 32'(bus.running), 32'd0);
    bus.start = 1; bus.stop = 1;
    step();
    lit("idle_both", 0, 5, 0);
    bus.start = 0; bus.stop = 0;

    // LFSR mode, seed 0 loads 1: map(1)=D, then map(8)=4, map(4)=7.
    bus.mode = 1; bus.seed = '0; bus.start = 1; bus.out_ready = 0;
    step(); bus.start = 0;
    lit("lfsr0", 'hD, 0, 1);
    bus.out_ready = 1;
    step(); lit("lfsr1", 'h4, 1, 1);
    step(); lit("lfsr2", 'h7, 2, 1);
    bus.start = 1; bus.stop = 1;
    step(); bus.start = 0; bus.stop = 0;
    lit("run_both", 0, 3, 0);
    check("run_both_running", 32'(bus.running), 32'd0);

    bus.mode = 0; bus.seed = 12'd3; bus.prev = 12'd2; bus.start = 1;
    step(); bus.start = 0;
    lit("wrap_start", 'hF, 0, 1);
    repeat (16) step();
    lit("wrap16", 'hF, 0, 1);
    step(); lit("wrap17", 'h3, 1, 1);

    #2 rst = 1'b1;
    #1;
    lit("async_rst", 0, 0, 0);
    check("async_rst_data", 32'(bus.data_out), 32'd0);
    check("async_rst_running", 32'(bus.running), 32'd0);
`ifdef DESEN_GEN_PARITY_EN
    check("async_rst_par", 32'(bus.par_out), 32'd0);
`endif
    step(); step();
    rst = 1'b0;
    step();

    bus.mode = 1; bus.seed = '0; bus.start = 1; bus.out_ready = 1;
    step(); bus.start = 0;
    repeat (4095) step();
    lit("lfsr_period", 'hD, 15, 1);

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.stop      = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.mode      = $urandom_range(0, 1);
      bus.seed      = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom_range(0, 4095));
      bus.prev      = SW'($urandom_range(0, 4095));
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/desen_gen.md
DESEN_GEN -- requirements
Module: desen_gen

Interface
REQ-001 SHALL have parameter DW, default 4, output data width in bits (2..8).
REQ-002 SHALL have parameter SW, default 12, seed/prev/LFSR width in bits (DW..32).
REQ-003 SHALL have parameter POLY, default 12'hE08, right-shift Galois LFSR tap mask (SW bits).
REQ-004 SHALL have parameter MAP_KEY, default 4'h5, DW-bit XOR key applied by the output mapper.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  start pulse, sampled each cycle.
REQ-008 SHALL have port stop  input  1  stop pulse, sampled each cycle.
REQ-009 SHALL have port mode  input  1  0 = sum mode, 1 = LFSR mode; sampled only on accepted start.
REQ-010 SHALL have port seed  input  SW  seed value.
REQ-011 SHALL have port prev  input  SW  previous-value operand for sum mode.
REQ-012 SHALL have port out_ready  input  1  consumer ready.
REQ-013 SHALL have port data_out  output  DW  registered generated word.
REQ-014 SHALL have port out_valid  output  1  data_out holds a valid word.
REQ-015 SHALL have port running  output  1  high in RUN or HOLD.
REQ-016 SHALL have port count  output  DW  accepted-word counter.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HOLD; reset state IDLE.
REQ-018 IDLE: start=1 and stop=0 -> RUN; mode latched; count cleared; LFSR loaded with seed (seed==0 loads 1).
REQ-019 RUN: out_valid=1; out_ready=0 -> HOLD; out_ready=1 -> word accepted, stays RUN.
REQ-020 HOLD: out_valid=1, data_out frozen; out_ready=1 -> accept, back to RUN.
REQ-021 stop=1 in RUN or HOLD -> IDLE next cycle, out_valid=0; a word offered that same cycle and accepted counts as accepted.
REQ-022 start and stop both 1 in the same cycle: stop wins; start ignored in every state.
REQ-023 start while RUN/HOLD: ignored, no reload.
REQ-024 On each accepted word, count increments by 1, wrapping modulo 2^DW (2^DW-1 -> 0).
REQ-025 Sum mode: next word = map((seed + prev + count) mod 2^DW), using count after increment; seed/prev sampled live.
REQ-026 LFSR mode: on accept, lfsr = (lfsr>>1) XOR (lfsr[0] ? POLY : 0); next word = map(lfsr[DW-1:0]) of the updated value.
REQ-027 map(x) = bit-reverse(x) XOR MAP_KEY.
REQ-028 Latency: first valid word appears one cycle after accepted start, computed from count=0 or the loaded LFSR.
REQ-029 LFSR SHALL never hold zero; the zero state is forced to 1.
REQ-030 In IDLE, data_out and count SHALL hold their last values; out_valid=0.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, data_out=0, out_valid=0, running=0, count=0, lfsr=1, latched mode=0.
REQ-032 Reset mid-operation SHALL abort immediately; no word is accepted in the reset cycle.

Configuration
REQ-033 When DESEN_GEN_PARITY_EN is defined, SHALL add output port par_out (1 bit, registered, even parity of data_out, valid with out_valid, reset 0); when it is undefined, par_out SHALL be absent and behaviour is otherwise identical.

Structure
REQ-034 A shared package desen_pkg SHALL hold the FSM state enum, the mode encoding, and the default POLY/MAP_KEY constants.
REQ-035 The mapper SHALL be a combinational sub-module desen_map (parameters DW, MAP_KEY).

Verification
REQ-036 Sum mode, seed=3, prev=2, out_ready=1, start pulse: words map(0x6), map(0x7), map(0x8)...; count 1,2,3.
REQ-037 LFSR mode, seed=0: LFSR loads 1, first word map(0x1)=0x8^0x5=0xD; sequence period 4095 accepted words.
REQ-038 out_ready=0 for 5 cycles in RUN: HOLD, data_out stable, count unchanged; out_ready=1 -> next word in 1 cycle.
REQ-039 start and stop both high in IDLE: stays IDLE; both high in RUN: IDLE next cycle, out_valid=0.
REQ-040 Count wrap: 16 accepts at DW=4 -> count=0; rst asserted mid-RUN -> all outputs 0 asynchronously.
